// File: rtl/riscv_pkg.sv
// Shared types for the core's load/store path and the data-memory responder.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      MemByte,
      MemHalf,
      MemWord,
      MemRsvd
   } mem_size_e;

   typedef enum logic [1:0] {
      DmemIdle,
      DmemAccess,
      DmemResp
   } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for the data-memory responder.
// Loads: extracts the addressed byte/half/word from the stored word and
// sign- or zero-extends it. Stores: produces per-byte write strobes and the
// store data replicated onto every lane, so the strobes select what lands.
// Half accesses ignore lane[0] and word accesses ignore the lane entirely;
// size 11 behaves as a word. Misalignment is flagged elsewhere when enabled.
module dmem_lane_align
   import riscv_pkg::*;
(
   input  logic [1:0]      lane_i,
   input  mem_size_e       size_i,
   input  logic            unsigned_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rword_i,
   output logic [XLEN-1:0] rdata_o,
   output logic [3:0]      wstrb_o,
   output logic [XLEN-1:0] wdata_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Lane extraction, extension and store strobe generation.
   always_comb begin
      rdata_o = '0;
      wstrb_o = '0;
      wdata_o = '0;
      byte_v  = rword_i[{lane_i, 3'b000} +: 8];
      half_v  = rword_i[{lane_i[1], 4'b0000} +: 16];
      case (size_i)
         MemByte: begin
            rdata_o = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            wstrb_o = 4'b0001 << lane_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         MemHalf: begin
            rdata_o = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            wstrb_o = lane_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: begin
            rdata_o = rword_i;
            wstrb_o = 4'b1111;
            wdata_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the core's load/store interface.
// One request at a time; access completes LATENCY cycles after acceptance,
// then the response is held until consumed.
// Optional build macro DMEM_ERR_CHECK_EN: flags misaligned, reserved-size and
// out-of-range accesses as faults (no write, zero data). Without it the fault
// output is tied low and addresses wrap modulo the array size.
//
// state      | meaning
// DmemIdle   | ready for a request
// DmemAccess | counting down latency; commit at terminal count
// DmemResp   | response valid, waiting for consumer
module dmem_responder
   import riscv_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [XLEN-1:0] req_addr_i,
   input  logic            req_we_i,
   input  logic [1:0]      req_size_i,
   input  logic            req_unsigned_i,
   input  logic [XLEN-1:0] req_wdata_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] rsp_rdata_o,
   output logic            rsp_err_o
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   dmem_state_e     state_q;
   logic [XLEN-1:0] addr_q;
   logic            we_q;
   mem_size_e       size_q;
   logic            uns_q;
   logic [XLEN-1:0] wdata_q;
   logic [CW-1:0]   cnt_q;
   logic            rsp_valid_q;
   logic [XLEN-1:0] rsp_rdata_q;
   logic            rsp_err_q;

   logic [XLEN-1:0] mem_q [MEM_WORDS];

   logic [AW-1:0]   word_idx;
   logic [XLEN-1:0] rword;
   logic [XLEN-1:0] rdata_ext;
   logic [3:0]      wstrb;
   logic [XLEN-1:0] wdata_al;
   logic            commit;
   logic            mem_we;
   logic            err_d;
   logic [XLEN-1:0] rsp_rdata_d;

   assign word_idx = addr_q[AW+1:2];
   assign rword    = mem_q[word_idx];
   assign commit   = (state_q == DmemAccess) && (cnt_q == '0);

   dmem_lane_align u_align (
      .lane_i     (addr_q[1:0]),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .wdata_i    (wdata_q),
      .rword_i    (rword),
      .rdata_o    (rdata_ext),
      .wstrb_o    (wstrb),
      .wdata_o    (wdata_al)
   );

`ifdef DMEM_ERR_CHECK_EN
   // Fault classification of the captured request.
   always_comb begin
      err_d = 1'b0;
      if (size_q == MemRsvd)                          err_d = 1'b1;
      if ((size_q == MemHalf) && addr_q[0])           err_d = 1'b1;
      if ((size_q == MemWord) && (addr_q[1:0] != 2'b00)) err_d = 1'b1;
      if (addr_q[XLEN-1:AW+2] != '0)                  err_d = 1'b1;
   end
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_q[XLEN-1:AW+2];
   assign err_d          = 1'b0;
`endif

   assign rsp_rdata_d = (we_q || err_d) ? '0 : rdata_ext;
   assign mem_we      = commit && we_q && !err_d && !rst_i;

   // Request/response sequencing and registered response outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= DmemIdle;
         addr_q      <= '0;
         we_q        <= 1'b0;
         size_q      <= MemByte;
         uns_q       <= 1'b0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            DmemIdle: begin
               if (req_valid_i) begin
                  addr_q  <= req_addr_i;
                  we_q    <= req_we_i;
                  size_q  <= mem_size_e'(req_size_i);
                  uns_q   <= req_unsigned_i;
                  wdata_q <= req_wdata_i;
                  cnt_q   <= CW'(LATENCY - 1);
                  state_q <= DmemAccess;
               end
            end
            DmemAccess: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= rsp_rdata_d;
                  rsp_err_q   <= err_d;
                  state_q     <= DmemResp;
               end
            end
            DmemResp: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  state_q     <= DmemIdle;
               end
            end
            default: state_q <= DmemIdle;
         endcase
      end
   end

   // Array write at the commit edge only; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem_q[word_idx][8*b +: 8] <= wdata_al[8*b +: 8];
         end
      end
   end

   assign req_ready_o = (state_q == DmemIdle) && !rst_i;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule
